bus_gate_arbiter: RTL and testbench
===================================

# bus_gate_arbiter

Parametrised, registered N-channel arbiter and driver for the datapath bus. It replaces the one-hot gate-select scheme with a clocked arbiter that tolerates multiple simultaneous gate requests, resolves them by fixed priority or round-robin, and reports contention. It sits between the gated datapath sources (ALU, MARMUX, MDR, PC, and future sources) and every bus consumer (IR, MAR, MDR, register file, PC mux).

## Interface
- WIDTH, 16, bus data width in bits (1..32)
- N, 4, number of source channels (2..16)
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- HOLD, 1, idle behaviour: 1 = Bus keeps its last granted value, 0 = Bus driven to all-zero
- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-low reset
- Data  input  N*WIDTH  channel data; channel i = Data[i*WIDTH +: WIDTH]
- Gate  input  N  per-channel drive request; bit i = channel i wants the bus
- Clear_Err  input  1  synchronous clear of Contention and Contention_Count
- Bus  output  WIDTH  registered bus value
- Bus_Valid  output  1  high when Bus carries a value granted in the previous cycle
- Grant  output  N  registered one-hot grant (all-zero when idle)
- Contention  output  1  sticky flag: two or more Gate bits were high in some cycle
- Contention_Count  output  8  saturating count of contention cycles

## Operation
- Each cycle Gate is sampled and a winner w is chosen; the result is registered.
- Zero Gate bits: Grant <= 0, Bus_Valid <= 0; Bus <= Bus if HOLD=1, else Bus <= 0. Round-robin pointer unchanged.
- Exactly one Gate bit i: w = i regardless of MODE.
- Two or more Gate bits (contention):
  - MODE=0: w = lowest set index.
  - MODE=1: w = first set index found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Contention <= 1; Contention_Count <= Contention_Count+1, saturating at 255 (never wraps to 0).
- On any grant: Bus <= Data[w*WIDTH +: WIDTH], Grant <= (1<<w), Bus_Valid <= 1.
- Round-robin pointer ptr (width ceil(log2 N)), used only when MODE=1: after grant to w, ptr <= (w+1) mod N; w=N-1 wraps ptr to 0. In MODE=0 ptr stays 0.
- Clear_Err=1: Contention <= 0, Contention_Count <= 0, unless the same cycle is a contention cycle, in which case Contention <= 1 and Contention_Count <= 1 (new event wins over clear).
- Clear_Err has no effect on Bus, Bus_Valid, Grant, or ptr.
- Data of non-granted channels never affects Bus.

## Timing
- Latency: Gate/Data at edge k appear on Bus/Grant/Bus_Valid after edge k (one cycle); throughput one grant per cycle.
- No back-pressure: every cycle with a Gate bit produces exactly one grant; losing channels are not queued and must re-assert Gate.
- Reset low (asynchronous, immediate, any cycle including mid-burst): Bus=0, Bus_Valid=0, Grant=0, Contention=0, Contention_Count=0, ptr=0. First grant possible on the first rising edge after Reset goes high.
- Outputs are purely registered; no combinational path from any input to any output.

## Test plan
- Reset mid-stream: WIDTH=16, N=4, Gate=0001, Data ch0=0x1234 for 3 cycles, drop Reset low asynchronously between edges -> Bus=0x0000, Bus_Valid=0, Grant=0000 immediately; Gate=0010, ch1=0xBEEF after release -> Bus=0xBEEF, Grant=0010 one edge later.
- Single requester / idle hold: Gate=0100, ch2=0x00AA, then Gate=0000 -> Bus=0x00AA, Bus_Valid=1, then Bus_Valid=0 with Bus=0x00AA (HOLD=1) or Bus=0x0000 (HOLD=0); Contention stays 0.
- Fixed priority: MODE=0, Gate=1010 for 3 cycles -> Grant=0010 every cycle, Contention=1, Contention_Count=3.
- Round-robin rotation: MODE=1, Gate=1111 held 6 cycles -> Grant sequence 0001,0010,0100,1000,0001,0010; Gate=1001 next from ptr=2 -> Grant=1000 then 0001 (wrap).
- Counter saturation and clear: 300 contention cycles -> Contention_Count=255 (not 44); Clear_Err with Gate=0001 -> count=0, Contention=0; Clear_Err with Gate=0011 -> count=1, Contention=1.
- Data isolation: Gate=0001, ch0=0x5555, ch1..ch3 toggling randomly each cycle -> Bus stays 0x5555 every cycle.

Source files
------------

// File: rtl/bus_gate_arbiter.sv
// Registered N-channel bus arbiter and driver: samples per-channel gate requests,
// picks one winner (fixed priority or round-robin), drives the bus and reports contention.
module bus_gate_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int HOLD  = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] Data,
    input  logic [N-1:0]       Gate,
    input  logic               Clear_Err,
    output logic [WIDTH-1:0]   Bus,
    output logic               Bus_Valid,
    output logic [N-1:0]       Grant,
    output logic               Contention,
    output logic [7:0]         Contention_Count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             bus_valid_q, bus_valid_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             contention_q, contention_d;
    logic [7:0]       contention_count_q, contention_count_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic             any_req;
    logic             multi_req;
    logic [PW-1:0]    win_fp;
    logic [PW-1:0]    win_rr;
    logic [PW-1:0]    win;
    logic [WIDTH-1:0] win_data;
    logic             found_fp;
    logic             found_rr;
    int               req_count;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        req_count = 0;
        win_fp    = '0;
        win_rr    = '0;
        found_fp  = 1'b0;
        found_rr  = 1'b0;

        for (int i = 0; i < N; i++) begin
            req_count = req_count + int'(Gate[i]);
            if (!found_fp && Gate[i]) begin
                win_fp   = PW'(i);
                found_fp = 1'b1;
            end
        end

        // Round-robin: first requester at or above ptr, otherwise wrap to the lowest requester.
        for (int i = 0; i < N; i++) begin
            if (!found_rr && Gate[i] && (i >= int'(ptr_q))) begin
                win_rr   = PW'(i);
                found_rr = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_rr && Gate[i]) begin
                win_rr   = PW'(i);
                found_rr = 1'b1;
            end
        end

        any_req   = (req_count != 0);
        multi_req = (req_count >= 2);
        win       = (MODE == 1) ? win_rr : win_fp;

        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win == PW'(i)) begin
                win_data = Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus_d              = bus_q;
        bus_valid_d        = 1'b0;
        grant_d            = '0;
        ptr_d              = ptr_q;
        contention_d       = contention_q;
        contention_count_d = contention_count_q;

        if (any_req) begin
            bus_d       = win_data;
            bus_valid_d = 1'b1;
            for (int i = 0; i < N; i++) begin
                grant_d[i] = (win == PW'(i));
            end
            if (MODE == 1) begin
                ptr_d = (int'(win) == N - 1) ? '0 : win + PW'(1);
            end
        end else if (HOLD == 0) begin
            bus_d = '0;
        end

        // A contention event in the same cycle as a clear restarts the count at one.
        if (multi_req) begin
            contention_d = 1'b1;
            if (Clear_Err) begin
                contention_count_d = 8'd1;
            end else if (contention_count_q != 8'hFF) begin
                contention_count_d = contention_count_q + 8'd1;
            end
        end else if (Clear_Err) begin
            contention_d       = 1'b0;
            contention_count_d = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus_q              <= '0;
            bus_valid_q        <= 1'b0;
            grant_q            <= '0;
            contention_q       <= 1'b0;
            contention_count_q <= 8'd0;
            ptr_q              <= '0;
        end else begin
            bus_q              <= bus_d;
            bus_valid_q        <= bus_valid_d;
            grant_q            <= grant_d;
            contention_q       <= contention_d;
            contention_count_q <= contention_count_d;
            ptr_q              <= ptr_d;
        end
    end

    assign Bus              = bus_q;
    assign Bus_Valid        = bus_valid_q;
    assign Grant            = grant_q;
    assign Contention       = contention_q;
    assign Contention_Count = contention_count_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Bench for bus_gate_arbiter: a fixed-priority/hold instance and a round-robin/zero-idle
// instance share one stimulus stream; expected results go through a scoreboard queue.
module tb_bus_gate_arbiter;

    typedef struct {
        logic [3:0]  gate;
        logic [15:0] d0, d1, d2, d3;
        logic        clr;
        logic [3:0]  g_fp, g_rr;
        logic [15:0] b_fp, b_rr;
        logic        valid;
        logic        cont;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  g_fp, g_rr;
        logic [15:0] b_fp, b_rr;
        logic        valid;
        logic        cont;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] data;
    logic [3:0]  gate;
    logic        clr;

    logic [15:0] bus_fp, bus_rr;
    logic        valid_fp, valid_rr;
    logic [3:0]  grant_fp, grant_rr;
    logic        cont_fp, cont_rr;
    logic [7:0]  cnt_fp, cnt_rr;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    bus_gate_arbiter #(.WIDTH(16), .N(4), .MODE(0), .HOLD(1)) u_fp (
        .Clk(clk), .Reset(rst_n), .Data(data), .Gate(gate), .Clear_Err(clr),
        .Bus(bus_fp), .Bus_Valid(valid_fp), .Grant(grant_fp),
        .Contention(cont_fp), .Contention_Count(cnt_fp)
    );

    bus_gate_arbiter #(.WIDTH(16), .N(4), .MODE(1), .HOLD(0)) u_rr (
        .Clk(clk), .Reset(rst_n), .Data(data), .Gate(gate), .Clear_Err(clr),
        .Bus(bus_rr), .Bus_Valid(valid_rr), .Grant(grant_rr),
        .Contention(cont_rr), .Contention_Count(cnt_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input exp_t e);
        check("grant_fp",   32'(grant_fp), 32'(e.g_fp));
        check("grant_rr",   32'(grant_rr), 32'(e.g_rr));
        check("bus_fp",     32'(bus_fp),   32'(e.b_fp));
        check("bus_rr",     32'(bus_rr),   32'(e.b_rr));
        check("valid_fp",   32'(valid_fp), 32'(e.valid));
        check("valid_rr",   32'(valid_rr), 32'(e.valid));
        check("cont_fp",    32'(cont_fp),  32'(e.cont));
        check("cont_rr",    32'(cont_rr),  32'(e.cont));
        check("count_fp",   32'(cnt_fp),   32'(e.cnt));
        check("count_rr",   32'(cnt_rr),   32'(e.cnt));
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'(0), 32'(1));
        end else begin
            e = sb_q.pop_front();
            check_all(e);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        gate = v.gate;
        data = {v.d3, v.d2, v.d1, v.d0};
        clr  = v.clr;
        e = '{g_fp: v.g_fp, g_rr: v.g_rr, b_fp: v.b_fp, b_rr: v.b_rr,
              valid: v.valid, cont: v.cont, cnt: v.cnt};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        gate  = '0;
        data  = '0;
        clr   = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[10];
    vec_t v;
    exp_t zero_e;

    initial begin
        tbl[0] = '{4'b0100, 16'h1111, 16'h2222, 16'h00AA, 16'h4444, 1'b0,
                   4'b0100, 4'b0100, 16'h00AA, 16'h00AA, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{4'b0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0,
                   4'b0000, 4'b0000, 16'h00AA, 16'h0000, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{4'b1010, 16'h0000, 16'hB1B1, 16'h0000, 16'hD3D3, 1'b0,
                   4'b0010, 4'b1000, 16'hB1B1, 16'hD3D3, 1'b1, 1'b1, 8'd1};
        tbl[3] = '{4'b1010, 16'h0000, 16'hB1B1, 16'h0000, 16'hD3D3, 1'b0,
                   4'b0010, 4'b0010, 16'hB1B1, 16'hB1B1, 1'b1, 1'b1, 8'd2};
        tbl[4] = '{4'b1010, 16'h0000, 16'hB1B1, 16'h0000, 16'hD3D3, 1'b0,
                   4'b0010, 4'b1000, 16'hB1B1, 16'hD3D3, 1'b1, 1'b1, 8'd3};
        tbl[5] = '{4'b0001, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 1'b1,
                   4'b0001, 4'b0001, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 8'd0};
        tbl[6] = '{4'b0011, 16'h0101, 16'h0202, 16'h0000, 16'h0000, 1'b1,
                   4'b0001, 4'b0010, 16'h0101, 16'h0202, 1'b1, 1'b1, 8'd1};
        tbl[7] = '{4'b0000, 16'h7777, 16'h7777, 16'h7777, 16'h7777, 1'b1,
                   4'b0000, 4'b0000, 16'h0101, 16'h0000, 1'b0, 1'b0, 8'd0};
        tbl[8] = '{4'b1001, 16'hA0A0, 16'h0000, 16'h0000, 16'hA3A3, 1'b0,
                   4'b0001, 4'b1000, 16'hA0A0, 16'hA3A3, 1'b1, 1'b1, 8'd1};
        tbl[9] = '{4'b1001, 16'hA0A0, 16'h0000, 16'h0000, 16'hA3A3, 1'b0,
                   4'b0001, 4'b0001, 16'hA0A0, 16'hA0A0, 1'b1, 1'b1, 8'd2};
        zero_e = '{g_fp: 4'b0, g_rr: 4'b0, b_fp: 16'h0, b_rr: 16'h0,
                   valid: 1'b0, cont: 1'b0, cnt: 8'd0};

        // Reset state before any clock edge.
        rst_n = 1'b0;
        gate  = '0;
        data  = '0;
        clr   = 1'b0;
        #1;
        check_all(zero_e);
        do_reset();

        // Reset asserted mid-stream clears outputs immediately, first grant one edge after release.
        for (int k = 0; k < 3; k++) begin
            apply('{4'b0001, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                    4'b0001, 4'b0001, 16'h1234, 16'h1234, 1'b1, 1'b0, 8'd0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all(zero_e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply('{4'b0010, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 1'b0,
                4'b0010, 4'b0010, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 8'd0});

        // Table: idle hold, fixed priority vs round-robin, clear interactions.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i]);
        end

        // Round-robin full rotation, then wrap from ptr=2.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            apply('{4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0,
                    4'b0001, 4'(1 << (k % 4)), 16'hC000, 16'(16'hC000 + (k % 4)),
                    1'b1, 1'b1, 8'(k + 1)});
        end
        apply('{4'b1001, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0,
                4'b0001, 4'b1000, 16'hC000, 16'hC003, 1'b1, 1'b1, 8'd7});
        apply('{4'b1001, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b0,
                4'b0001, 4'b0001, 16'hC000, 16'hC000, 1'b1, 1'b1, 8'd8});

        // Counter saturation over 300 contention cycles, then clear behaviour.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            apply('{4'b0011, 16'hE000, 16'hE001, 16'h0000, 16'h0000, 1'b0,
                    4'b0001, (k % 2 == 0) ? 4'b0001 : 4'b0010,
                    16'hE000, (k % 2 == 0) ? 16'hE000 : 16'hE001,
                    1'b1, 1'b1, (k + 1 >= 255) ? 8'd255 : 8'(k + 1)});
        end
        apply('{4'b0001, 16'hF000, 16'hF001, 16'h0000, 16'h0000, 1'b1,
                4'b0001, 4'b0001, 16'hF000, 16'hF000, 1'b1, 1'b0, 8'd0});
        apply('{4'b0011, 16'hF000, 16'hF001, 16'h0000, 16'h0000, 1'b1,
                4'b0001, 4'b0010, 16'hF000, 16'hF001, 1'b1, 1'b1, 8'd1});

        // Data isolation: non-granted channels toggle randomly.
        for (int k = 0; k < 20; k++) begin
            v = '{4'b0001, 16'h5555, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0,
                  4'b0001, 4'b0001, 16'h5555, 16'h5555, 1'b1, 1'b1, 8'd1};
            apply(v);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
